// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/limits, serial-adder state encoding,
// decimal correction constant and an invalid-digit helper.
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int BCD_CORR      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  function automatic logic bcd_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: binary sum of two digits plus carry, corrected by
// +6 when the sum exceeds 9. Non-BCD inputs pass through the same formula.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a_d,
  input  logic [BCD_DIGIT_W-1:0] b_d,
  input  logic                   c_in,
  output logic [BCD_DIGIT_W-1:0] s_d,
  output logic                   c_out
);

  logic [BCD_DIGIT_W:0] s_bin;
  logic [BCD_DIGIT_W:0] s_cor;

  always_comb begin
    s_bin = {1'b0, a_d} + {1'b0, b_d} + {{BCD_DIGIT_W{1'b0}}, c_in};
    s_cor = s_bin + (BCD_DIGIT_W+1)'(BCD_CORR);
    if (s_bin > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT)) begin
      s_d   = s_cor[BCD_DIGIT_W-1:0];
      c_out = 1'b1;
    end else begin
      s_d   = s_bin[BCD_DIGIT_W-1:0];
      c_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_adder_serial.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock, start/done handshake.
// Optional invalid-digit flag enabled by defining BCD_ADD_INPUT_CHECK_EN.
module bcd_adder_serial
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] b,
  input  logic                           cin,
  output logic                           busy,
  output logic                           done,
  output logic [BCD_DIGIT_W*NDIGITS-1:0] sum,
  output logic                           cout,
  output logic                           err
);

  localparam int W     = BCD_DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIGITS - 1);

  bcd_state_e       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q, b_q;

  logic [BCD_DIGIT_W-1:0] a_d, b_d, s_d;
  logic                   c_next;

  always_comb begin
    a_d = a_q[int'(idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
    b_d = b_q[int'(idx)*BCD_DIGIT_W +: BCD_DIGIT_W];
  end

  // One digit slice, time-shared across all digit positions.
  bcd_digit_add u_dig (
    .a_d   (a_d),
    .b_d   (b_d),
    .c_in  (carry),
    .s_d   (s_d),
    .c_out (c_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            sum   <= '0;
            cout  <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[int'(idx)*BCD_DIGIT_W +: BCD_DIGIT_W] <= s_d;
          carry <= c_next;
          if (idx == LAST) begin
            cout  <= c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_ADD_INPUT_CHECK_EN
  logic err_q;

  // Sticky across the operation; cleared only by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (state != RUN && start)
      err_q <= 1'b0;
    else if (state == RUN && (bcd_invalid(a_d) || bcd_invalid(b_d)))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed self-checking bench for bcd_adder_serial (NDIGITS=4): vector table
// plus hand-written sequences for back-to-back, operand latching and reset.
module tb_bcd_adder_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int checks   = 0;
  int failures = 0;

`ifdef BCD_ADD_INPUT_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  bcd_adder_serial #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vc;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for done after an accept edge; returns cycles from accept (0 = timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      chk("busy_during_run", busy, (k < 4) ? 1 : 0);
    end
  endtask

  task automatic run_vec(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    wait_done(lat);
    chk("latency", lat, 4);
    chk("busy_at_done", busy, 0);
  endtask

  vec_t vecs[$];
  int   lat;
  logic [15:0] held;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    vecs.push_back('{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0});
    vecs.push_back('{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0});
    vecs.push_back('{16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, ERR_ON});
    vecs.push_back('{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    chk("rst_err",  err,  0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i].va, vecs[i].vb, vecs[i].vc);
      chk($sformatf("sum[%0d]", i),  sum,  vecs[i].exp_sum);
      chk($sformatf("cout[%0d]", i), cout, vecs[i].exp_cout);
      chk($sformatf("err[%0d]", i),  err,  vecs[i].exp_err);
    end

    // Result holds after done; done is a single pulse.
    held = sum;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_sum", sum, held);
    chk("hold_done", done, 0);

    // start held high, operands changed during RUN, second op begins in done cycle.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222;
    wait_done(lat);
    chk("b2b_lat1", lat, 4);
    chk("b2b_sum1", sum, 16'h6912);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    chk("b2b_sum_cleared", sum, 0);
    wait_done(lat);
    chk("b2b_lat2", lat, 4);
    chk("b2b_sum2", sum, 16'h3333);
    chk("b2b_cout2", cout, 0);

    // Reset at digit 2 of an operation.
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum",  sum,  0);
    chk("mid_rst_cout", cout, 0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      chk("no_done_after_rst", seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_adder_serial.md
# bcd_adder_serial

Digit-serial BCD adder: adds two N-digit packed-BCD operands plus carry-in, one digit per clock, least significant digit first. Companion to the team's combinational BCD subtractor: same packed-BCD operand format, addition instead of subtraction, and sequential with a start/done handshake. Sits in the datapath wherever area matters more than latency, e.g. accumulating BCD counters and display totals.

## Interface
- NDIGITS, default 4: number of BCD digits per operand (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request; sampled only when busy=0.
- a  in  4*NDIGITS  addend A, packed BCD, digit 0 in a[3:0].
- b  in  4*NDIGITS  addend B, same packing.
- cin  in  1  carry-in to digit 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: sum/cout valid.
- sum  out  4*NDIGITS  BCD result, packed like a.
- cout  out  1  carry-out of the most significant digit.
- err  out  1  invalid-digit flag. Exists unconditionally; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch a, b, cin into operand/carry registers. Clear sum and cout to 0, digit index to 0, err to 0. Go to RUN.
- IDLE/DONE with start=0: DONE goes to IDLE. IDLE holds.
- RUN, each cycle, for digit i = index:
  - s = A[i] + B[i] + carry, 5-bit.
  - If s > 9: digit = (s + 6)[3:0], carry = 1. Otherwise digit = s[3:0], carry = 0.
  - Write the digit into sum[4i+:4].
  - When i = NDIGITS-1: cout = new carry, go to DONE. Otherwise increment the index.
- start is ignored while in RUN. Latched operands are immune to later changes on a/b/cin.
- sum and cout hold their values after DONE until the next accepted start.
- Non-BCD input digits (>9) are not rejected. The formula above is applied as-is.
- Reset (rst_n=0 at an edge), including mid-operation: state IDLE. busy, done, sum, cout, err, index and carry all 0.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0.
- Start accepted at edge E0 (start=1, busy=0). Then:
  - busy=1 after E0 through edge E0+NDIGITS.
  - Digit i is written at edge E0+1+i.
  - done=1 for exactly the cycle after edge E0+NDIGITS. busy is 0 in that cycle.
- Latency from accept to done is NDIGITS cycles.
- Back-to-back: start=1 during the done cycle is accepted. No idle cycle is required.
- done never asserts without a preceding accepted start.

## Configuration
- BCD_ADD_INPUT_CHECK_EN defined:
  - When each digit is processed in RUN, if A[i] > 9 or B[i] > 9, set err.
  - err is sticky until the next accepted start or reset.
  - err is valid together with done.
- BCD_ADD_INPUT_CHECK_EN undefined: err tied to 0. No check logic is synthesized.

## Structure
- Shared package bcd_pkg holds:
  - BCD_DIGIT_W = 4 and BCD_MAX_DIGIT = 9.
  - The state enum (IDLE, RUN, DONE).
  - The correction constant 6.
- One sub-module, bcd_digit_add, is combinational: (a_d, b_d, c_in) → (s_d, c_out). It is instantiated once and shared across cycles.
- Digit index counter width is $clog2(NDIGITS), minimum 1.

## Test plan
- NDIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse → done exactly 4 cycles after accept, sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Carry must propagate through all digits.
- a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0. Then a=0x4999, b=0x5000, cin=1 → sum=0x0000, cout=1.
- start held high throughout, with a/b changed during RUN → first result matches the operands latched at accept. A second operation starts in the done cycle and finishes 4 cycles later.
- rst_n=0 for one edge at digit 2 of an operation → next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows.
- With BCD_ADD_INPUT_CHECK_EN: a=0x000A, b=0x0000 → err=1 at done, cleared by the next start. Without the macro, err stays 0.
